// File: rtl/clk_enable_gen.sv
// N-channel clock-enable / divided-clock generator running off one PLL clock.
// Outputs are qualified on a debounced PLL lock and can be resynchronised at runtime.
module clk_enable_gen #(
  parameter int NUM_CH    = 3,
  parameter int DIV_W     = 16,
  parameter int LOCK_WAIT = 1024,
  parameter int DEF_DIV   = 125
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic [NUM_CH*DIV_W-1:0] phase_cfg,
  input  logic                    cfg_load,
  input  logic                    sync,
  input  logic                    lol_clr,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       clk_out,
  output logic                    ready,
  output logic                    lol_sticky
);

  localparam int SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t                        state, state_nxt;
  logic [SW-1:0]                 settle_cnt, settle_nxt;
  logic                          lk_meta, lk;
  logic [NUM_CH-1:0][DIV_W-1:0]  div_act, phase_act, cnt_q, cnt_nxt;
  logic [NUM_CH-1:0]             ce_nxt, clk_nxt;
  logic                          run_ok, resync, lol_set;

  // A divide of 0 behaves as 1; the phase is clamped into the counter range.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] n);
    return (n == '0) ? DIV_W'(1) : n;
  endfunction

  function automatic logic [DIV_W-1:0] eff_phase(input logic [DIV_W-1:0] p,
                                                 input logic [DIV_W-1:0] ne);
    return (p > ne - DIV_W'(1)) ? ne - DIV_W'(1) : p;
  endfunction

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      WAIT_LOCK: begin
        if (lk) begin
          state_nxt  = SETTLE;
          settle_nxt = '0;
        end
      end
      SETTLE: begin
        if (!lk) begin
          state_nxt  = WAIT_LOCK;
          settle_nxt = '0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt = RUN;
        end else begin
          settle_nxt = settle_cnt + SW'(1);
        end
      end
      RUN: begin
        if (!lk) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Channels only count while locked in RUN; any resync restarts every counter at 0 together.
  always_comb begin
    run_ok  = (state == RUN) && lk;
    resync  = cfg_load | sync;
    lol_set = (state == RUN) && !lk;
    cnt_nxt = '0;
    ce_nxt  = '0;
    clk_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (run_ok) begin
        ce_nxt[i]  = (cnt_q[i] == eff_phase(phase_act[i], eff_div(div_act[i])));
        clk_nxt[i] = (cnt_q[i] < (eff_div(div_act[i]) >> 1));
        if (!resync && (cnt_q[i] != eff_div(div_act[i]) - DIV_W'(1)))
          cnt_nxt[i] = cnt_q[i] + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      cnt_q      <= '0;
      ce_out     <= '0;
      clk_out    <= '0;
      ready      <= 1'b0;
      lol_sticky <= 1'b0;
      phase_act  <= '0;
      for (int i = 0; i < NUM_CH; i++) div_act[i] <= DIV_W'(DEF_DIV);
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      cnt_q      <= cnt_nxt;
      ce_out     <= ce_nxt;
      clk_out    <= clk_nxt;
      ready      <= (state_nxt == RUN);
      if (lol_set)      lol_sticky <= 1'b1;
      else if (lol_clr) lol_sticky <= 1'b0;
      if (cfg_load) begin
        div_act   <= div_cfg;
        phase_act <= phase_cfg;
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: a per-cycle expectation queue is filled from a
// modulo-count model of each channel and drained against the registered outputs.
module tb_clk_enable_gen;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 16;

  logic                    refclk;
  logic                    rst_n;
  logic                    pll_locked;
  logic [NUM_CH*DIV_W-1:0] div_cfg;
  logic [NUM_CH*DIV_W-1:0] phase_cfg;
  logic                    cfg_load;
  logic                    sync;
  logic                    lol_clr;
  logic [NUM_CH-1:0]       ce_out;
  logic [NUM_CH-1:0]       clk_out;
  logic                    ready;
  logic                    lol_sticky;

  clk_enable_gen #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .LOCK_WAIT(16),
    .DEF_DIV  (125)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .div_cfg   (div_cfg),
    .phase_cfg (phase_cfg),
    .cfg_load  (cfg_load),
    .sync      (sync),
    .lol_clr   (lol_clr),
    .ce_out    (ce_out),
    .clk_out   (clk_out),
    .ready     (ready),
    .lol_sticky(lol_sticky)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] clk;
    logic              ready;
    logic              lol;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // Model state: m_run means the channels counted during the cycle before the next edge.
  int m_ne[NUM_CH];
  int m_pe[NUM_CH];
  int k;
  bit m_run, m_ready, m_lol;

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  function automatic exp_t model_expect();
    exp_t e;
    e = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_run) begin
        e.ce[i]  = ((k % m_ne[i]) == m_pe[i]);
        e.clk[i] = ((k % m_ne[i]) < (m_ne[i] / 2));
      end
    end
    e.ready = m_ready;
    e.lol   = m_lol;
    return e;
  endfunction

  task automatic model_cfg(input int n0, input int p0, input int n1, input int p1,
                           input int n2, input int p2);
    int n[NUM_CH];
    int p[NUM_CH];
    n = '{n0, n1, n2};
    p = '{p0, p1, p2};
    for (int i = 0; i < NUM_CH; i++) begin
      m_ne[i] = (n[i] == 0) ? 1 : n[i];
      m_pe[i] = (p[i] > m_ne[i] - 1) ? m_ne[i] - 1 : p[i];
    end
  endtask

  task automatic drive_cfg(input int n0, input int p0, input int n1, input int p1,
                           input int n2, input int p2);
    div_cfg   = {DIV_W'(n2), DIV_W'(n1), DIV_W'(n0)};
    phase_cfg = {DIV_W'(p2), DIV_W'(p1), DIV_W'(p0)};
  endtask

  task automatic checkOutput();
    exp_t e;
    n_checks++;
    assert (exp_q.size() > 0) else begin
      n_fails++;
      $error("[TB] FAIL queue: observed empty expected entry");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      assert (ce_out === e.ce) else begin
        n_fails++;
        $error("[TB] FAIL ce_out k=%0d: observed %b expected %b", k, ce_out, e.ce);
      end
      n_checks++;
      assert (clk_out === e.clk) else begin
        n_fails++;
        $error("[TB] FAIL clk_out k=%0d: observed %b expected %b", k, clk_out, e.clk);
      end
      n_checks++;
      assert (ready === e.ready) else begin
        n_fails++;
        $error("[TB] FAIL ready: observed %b expected %b", ready, e.ready);
      end
      n_checks++;
      assert (lol_sticky === e.lol) else begin
        n_fails++;
        $error("[TB] FAIL lol_sticky: observed %b expected %b", lol_sticky, e.lol);
      end
    end
  endtask

  // One refclk cycle: drive strobes, queue the expected outputs, clock, then compare.
  task automatic applyStimulus(input bit ld, input bit sy, input bit clr);
    cfg_load = ld;
    sync     = sy;
    lol_clr  = clr;
    exp_q.push_back(model_expect());
    @(posedge refclk);
    #1;
    cfg_load = 1'b0;
    sync     = 1'b0;
    lol_clr  = 1'b0;
    if (m_run) k++;
    checkOutput();
  endtask

  task automatic run_cycles(input int n);
    for (int j = 0; j < n; j++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // pll_locked is already high: 2 synchroniser edges + 1 WAIT_LOCK edge + 16 SETTLE edges.
  task automatic wait_lock();
    m_run   = 1'b0;
    m_ready = 1'b0;
    run_cycles(18);
    m_ready = 1'b1;
    run_cycles(1);
    m_run = 1'b1;
    k     = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    cfg_load   = 1'b0;
    sync       = 1'b0;
    lol_clr    = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0);
    model_cfg(125, 0, 125, 0, 125, 0);
    m_run   = 1'b0;
    m_ready = 1'b0;
    m_lol   = 1'b0;
    k       = 0;

    #2 rst_n = 1'b0;
    @(posedge refclk);
    #1;
    exp_q.push_back(model_expect());
    checkOutput();
    rst_n = 1'b1;
    run_cycles(3);

    $display("[TB] lock glitch during SETTLE");
    pll_locked = 1'b1;
    run_cycles(9);
    pll_locked = 1'b0;
    run_cycles(1);
    pll_locked = 1'b1;
    wait_lock();

    $display("[TB] default divide 125, phase 0");
    run_cycles(130);

    $display("[TB] N=125/4/1, P=0/3/0");
    drive_cfg(125, 0, 4, 3, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    model_cfg(125, 0, 4, 3, 1, 0);
    k = 0;
    run_cycles(260);

    $display("[TB] phase clamp and sync");
    drive_cfg(10, 15, 7, 2, 2, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    model_cfg(10, 15, 7, 2, 2, 1);
    k = 0;
    run_cycles(25);
    applyStimulus(1'b0, 1'b1, 1'b0);
    k = 0;
    run_cycles(30);

    $display("[TB] loss of lock in RUN");
    pll_locked = 1'b0;
    run_cycles(2);
    m_run   = 1'b0;
    m_ready = 1'b0;
    m_lol   = 1'b1;
    run_cycles(3);
    drive_cfg(6, 2, 3, 1, 0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    model_cfg(6, 2, 3, 1, 0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pll_locked = 1'b1;
    wait_lock();
    run_cycles(20);

    $display("[TB] lol_clr, then clear colliding with a new loss");
    m_lol = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    run_cycles(5);
    pll_locked = 1'b0;
    run_cycles(2);
    m_run   = 1'b0;
    m_ready = 1'b0;
    m_lol   = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    run_cycles(2);

    $display("[TB] async reset mid-RUN");
    pll_locked = 1'b1;
    wait_lock();
    run_cycles(10);
    #3 rst_n = 1'b0;
    #1;
    m_run   = 1'b0;
    m_ready = 1'b0;
    m_lol   = 1'b0;
    exp_q.push_back(model_expect());
    checkOutput();
    model_cfg(125, 0, 125, 0, 125, 0);
    @(posedge refclk);
    #1 rst_n = 1'b1;
    wait_lock();
    run_cycles(130);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised N-channel clock-enable and divided-clock generator.
- Runs off one fast PLL output clock, e.g. the 125 MHz system clock.
- Replaces fixed, per-frequency PLL outputs with runtime-programmable divide ratio and phase per channel.
- Gates all outputs on qualified PLL lock.
- Provides a sticky loss-of-lock flag and a global resynchronisation input, so slow domains (1 MHz and below) are derived as clock enables rather than extra PLL counters.

Parameters:
- NUM_CH, 3, number of output channels.
- DIV_W, 16, width of each divide and phase field.
- LOCK_WAIT, 1024, consecutive synchronised-locked refclk cycles required before RUN; must be ≥1.
- DEF_DIV, 125, divide ratio loaded into every channel at reset.

Ports:
- refclk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
- div_cfg  in  NUM_CH*DIV_W  per-channel divide ratio N; channel i occupies bits [i*DIV_W +: DIV_W].
- phase_cfg  in  NUM_CH*DIV_W  per-channel enable phase P, same packing as div_cfg.
- cfg_load  in  1  one-cycle strobe: capture div_cfg/phase_cfg and resynchronise.
- sync  in  1  one-cycle strobe: resynchronise all channel counters.
- lol_clr  in  1  clears lol_sticky.
- ce_out  out  NUM_CH  one-refclk-wide enable pulse per channel period.
- clk_out  out  NUM_CH  divided square wave per channel.
- ready  out  1  high in RUN.
- lol_sticky  out  1  loss of lock seen while in RUN.

Behaviour:
- Reset (rst_n=0, async):
  - All outputs 0; state WAIT_LOCK.
  - Counters 0.
  - Active N = DEF_DIV, active P = 0.
  - Lock synchroniser cleared.
- pll_locked passes through a 2-flop synchroniser; lk denotes its output. This adds 2 cycles of latency.
- State machine:
  - WAIT_LOCK: counters held 0, ce_out/clk_out=0, ready=0. lk=1 -> SETTLE with settle counter=0.
  - SETTLE: settle counter increments each cycle lk=1. lk=0 -> WAIT_LOCK. Counter reaching LOCK_WAIT-1 with lk=1 -> RUN; ready=1 from the first RUN cycle.
  - RUN: channels count. lk=0 -> WAIT_LOCK next cycle, ready=0, lol_sticky=1, outputs forced 0 that same cycle.
- Channel counter c (DIV_W bits):
  - Effective divide Ne = max(N,1). Effective phase Pe = min(P, Ne-1).
  - c counts 0..Ne-1 and wraps to 0.
  - Outputs are registered from c, so an output reflects c one cycle later:
    - ce_out[i]=1 the cycle after c==Pe.
    - clk_out[i]=1 the cycle after c < (Ne>>1).
  - Ne=1: ce_out constant 1 in RUN, clk_out constant 0. Ne=2: clk_out = refclk/2.
- Resynchronisation on cfg_load (in any state):
  - Active N/P load from inputs.
  - In RUN, all counters reset to 0 in the same cycle.
  - On the next cycle, every channel's count starts from 0, so all channels are mutually phase-aligned.
- Resynchronisation on sync: in RUN, all counters reset to 0 and configuration is unchanged. Ignored outside RUN.
- Simultaneous cfg_load and sync: treated as cfg_load.
- cfg_load outside RUN updates configuration only; RUN entry always starts counters at 0.
- lol_sticky: set has priority over lol_clr in the same cycle. Unaffected by re-lock; only lol_clr or rst_n clears it.
- Width: all comparisons unsigned DIV_W-bit. N=2^DIV_W-1 is legal. No overflow beyond the wrap.

Test Plan:
- Lock qualification: LOCK_WAIT=16; raise pll_locked at t0 -> ready=1 exactly 2+16 cycles later (±1 for the RUN register) and ce_out first pulses at the configured phase.
- Lock glitch: drop pll_locked for 1 cycle midway through SETTLE -> settle counter restarts; ready rises only 16 cycles after re-lock; lol_sticky stays 0.
- Division and phase: N0=125 P0=0, N1=4 P1=3, N2=1, then cfg_load ->
  - ce_out[0] every 125 cycles with clk_out[0] high 62 cycles;
  - ce_out[1] every 4 cycles, one cycle after clk_out[1] falls;
  - ce_out[2] constantly 1.
- Phase clamp and resync: N=10 P=15 -> ce at count 9. Pulse sync mid-period -> every channel's next counting cycle is count 0, and all ce/clk edges realign.
- Loss of lock in RUN: drop pll_locked -> ready and outputs go 0 within 3 cycles; lol_sticky=1 persists through re-lock. Assert lol_clr and a new loss in the same cycle -> lol_sticky stays 1.
- Async reset mid-RUN: assert rst_n=0 between clock edges -> all outputs 0 immediately and divide returns to DEF_DIV (verified after re-lock).
